// File: rtl/cla_4b_if.sv
// Operand/result bundle for the 4-bit carry-lookahead adder leaf.
// Latency: none (wiring only); the adder defines timing.
// Backpressure: none; there is no ready signal, and results are produced every cycle.
// Ports: in_valid/CI/A/B carry the operands.
//        S/CO/PG/GG/out_valid carry the results.
// The master modport drives operands; the slave modport is the adder side.
interface cla_4b_if;
    logic       in_valid;
    logic       CI;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] S;
    logic       CO;
    logic       PG;
    logic       GG;
    logic       out_valid;

    modport master (
        output in_valid, CI, A, B,
        input  S, CO, PG, GG, out_valid
    );

    modport slave (
        input  in_valid, CI, A, B,
        output S, CO, PG, GG, out_valid
    );
endinterface

// File: rtl/cla_4b.sv
// 4-bit carry-lookahead adder: {CO,S} = A+B+CI, plus group PG/GG for cascading.
// Latency: 1 cycle when REG_OUT=1; 0 cycles (combinational) when REG_OUT=0.
// Backpressure: none; the adder accepts one operand set per cycle and never stalls.
// Ports: clk/rst (sync, active-high) drive the output registers.
//        io (slave) carries in_valid/CI/A/B in and S/CO/PG/GG/out_valid out.
module cla_4b #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    cla_4b_if.slave  io
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c0, c1, c2, c3, c4;
    logic       pg_c;
    logic       gg_c;
    logic [3:0] s_c;

    assign g = io.A & io.B;
    assign p = io.A ^ io.B;

    // Every carry is a flat sum of products of g/p and CI, so no carry waits
    // on another carry; depth is two gate levels regardless of bit position.
    assign c0 = io.CI;
    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);

    // Group terms let a second-level lookahead unit form this group's
    // carry-out as GG | PG&CI without waiting on c4.
    assign pg_c = &p;
    assign gg_c = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);

    assign s_c = p ^ {c3, c2, c1, c0};

    generate
        if (REG_OUT) begin : g_reg
            logic [3:0] s_q;
            logic       co_q;
            logic       pg_q;
            logic       gg_q;
            logic       vld_q;

            // Data loads every cycle; in_valid only travels alongside as the
            // qualifier, so the datapath carries no enable.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_q   <= 4'd0;
                    co_q  <= 1'b0;
                    pg_q  <= 1'b0;
                    gg_q  <= 1'b0;
                    vld_q <= 1'b0;
                end else begin
                    s_q   <= s_c;
                    co_q  <= c4;
                    pg_q  <= pg_c;
                    gg_q  <= gg_c;
                    vld_q <= io.in_valid;
                end
            end

            assign io.S         = s_q;
            assign io.CO        = co_q;
            assign io.PG        = pg_q;
            assign io.GG        = gg_q;
            assign io.out_valid = vld_q;
        end else begin : g_comb
            assign io.S         = s_c;
            assign io.CO        = c4;
            assign io.PG        = pg_c;
            assign io.GG        = gg_c;
            assign io.out_valid = io.in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_cla_4b.sv
module tb_cla_4b;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cla_4b_if io_r ();
    cla_4b_if io_c ();

    cla_4b #(.REG_OUT(1'b1)) dut_reg  (.clk(clk), .rst(rst), .io(io_r));
    cla_4b #(.REG_OUT(1'b0)) dut_comb (.clk(clk), .rst(rst), .io(io_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition; group terms from their definitions.
    // Packed as {out_valid, CO, PG, GG, S[3:0]}.
    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic ci, input logic v);
        int         total;
        logic [4:0] t5;
        logic       pg;
        logic       gg;
        total = int'(a) + int'(b) + int'(ci);
        t5    = total[4:0];
        pg    = ((a ^ b) == 4'hF);
        gg    = (int'(a) + int'(b)) >= 16;
        return {v, t5[4], pg, gg, t5[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {vld,co,pg,gg,s}=%b_%b_%b_%b_%h expected %b_%b_%b_%b_%h",
                     tag, got[7], got[6], got[5], got[4], got[3:0],
                     exp[7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Drive one operand set on the falling edge, check the combinational build
    // before the rising edge, then check the registered build just after it.
    task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic ci, input logic v, input logic r);
        logic [7:0] exp;
        @(negedge clk);
        rst = r;
        io_r.A = a; io_r.B = b; io_r.CI = ci; io_r.in_valid = v;
        io_c.A = a; io_c.B = b; io_c.CI = ci; io_c.in_valid = v;
        exp = model(a, b, ci, v);
        #1;
        chk({tag, "/comb"}, {io_c.out_valid, io_c.CO, io_c.PG, io_c.GG, io_c.S}, exp);
        @(posedge clk);
        #1;
        if (r) exp = 8'h00;
        chk({tag, "/reg"}, {io_r.out_valid, io_r.CO, io_r.PG, io_r.GG, io_r.S}, exp);
    endtask

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
    } vec_t;

    vec_t directed [] = '{
        '{4'd0,  4'd0,  1'b0}, '{4'd1,  4'd0,  1'b0}, '{4'd2,  4'd1,  1'b0},
        '{4'd2,  4'd3,  1'b0}, '{4'd3,  4'd3,  1'b0}, '{4'd7,  4'd3,  1'b0},
        '{4'd3,  4'd12, 1'b0}, '{4'd14, 4'd1,  1'b0}, '{4'd15, 4'd15, 1'b0},
        '{4'd10, 4'd0,  1'b0}, '{4'd3,  4'd4,  1'b0}, '{4'd3,  4'd6,  1'b0},
        '{4'd7,  4'd2,  1'b0}, '{4'd1,  4'd5,  1'b0}, '{4'd6,  4'd4,  1'b0},
        '{4'd15, 4'd0,  1'b1}, '{4'd0,  4'd0,  1'b1}, '{4'd15, 4'd15, 1'b1}
    };

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        logic       rv;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        io_r.A = 4'd0; io_r.B = 4'd0; io_r.CI = 1'b0; io_r.in_valid = 1'b0;
        io_c.A = 4'd0; io_c.B = 4'd0; io_c.CI = 1'b0; io_c.in_valid = 1'b0;

        // Two reset cycles; in_valid asserted on the second must be discarded.
        apply("reset0", 4'd5, 4'd6, 1'b1, 1'b0, 1'b1);
        apply("reset1", 4'd5, 4'd6, 1'b1, 1'b1, 1'b1);

        // Hand-computed anchors independent of the model.
        apply("anchor_7p3", 4'd7, 4'd3, 1'b0, 1'b1, 1'b0);
        chk("anchor_7p3_const", {io_r.out_valid, io_r.CO, io_r.PG, io_r.GG, io_r.S}, 8'b1_0_0_0_1010);
        apply("anchor_3p12", 4'd3, 4'd12, 1'b0, 1'b1, 1'b0);
        chk("anchor_3p12_const", {io_r.out_valid, io_r.CO, io_r.PG, io_r.GG, io_r.S}, 8'b1_0_1_0_1111);
        apply("anchor_15p0c", 4'd15, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("anchor_15p0c_const", {io_r.out_valid, io_r.CO, io_r.PG, io_r.GG, io_r.S}, 8'b1_1_1_0_0000);
        apply("anchor_15p15c", 4'd15, 4'd15, 1'b1, 1'b1, 1'b0);
        chk("anchor_15p15c_const", {io_r.out_valid, io_r.CO, io_r.PG, io_r.GG, io_r.S}, 8'b1_1_0_1_1111);

        foreach (directed[i])
            apply($sformatf("dir%0d", i), directed[i].a, directed[i].b, directed[i].ci, 1'b1, 1'b0);

        // All 512 operand combinations back to back.
        for (int k = 0; k < 512; k++) begin
            logic [8:0] kv;
            kv = 9'(k);
            apply("exh", kv[3:0], kv[7:4], kv[8], 1'b1, 1'b0);
        end

        // Reset mid-stream with a valid operand present; then recovery.
        apply("mid_pre", 4'd9, 4'd9, 1'b0, 1'b1, 1'b0);
        apply("mid_rst", 4'd9, 4'd9, 1'b0, 1'b1, 1'b1);
        apply("mid_post", 4'd9, 4'd9, 1'b0, 1'b1, 1'b0);
        chk("mid_post_const", {io_r.out_valid, io_r.CO, io_r.PG, io_r.GG, io_r.S}, 8'b1_1_0_1_0010);

        // in_valid toggling: out_valid follows (comb immediately, reg one cycle later).
        apply("vld_lo", 4'd7, 4'd3, 1'b0, 1'b0, 1'b0);
        apply("vld_hi", 4'd7, 4'd3, 1'b0, 1'b1, 1'b0);
        apply("vld_lo2", 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);

        // Random operands with random in_valid.
        for (int k = 0; k < 300; k++) begin
            ra = 4'($urandom_range(15, 0));
            rb = 4'($urandom_range(15, 0));
            rc = 1'($urandom_range(1, 0));
            rv = 1'($urandom_range(1, 0));
            apply("rand", ra, rb, rc, rv, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
